// File: rtl/card_dealer.sv
// card_dealer: LFSR card draw engine for the BlackJack datapath.
// Seeds from the free-running counter value on the first draw after reset.
// After each card it drives the Counter timer's clear/enable inputs to hold off the next draw.
module card_dealer #(
  parameter int unsigned WIDTH   = 12,   // seed width, at most 16
  parameter bit          HOLD_EN = 1'b1
) (
  input  logic             clk_50M,
  input  logic             i_Reset,
  input  logic [WIDTH-1:0] i_Seed,
  input  logic             i_TwoSec,
  input  logic             i_Draw,
  output logic             o_Ready,
  output logic [3:0]       o_Card,
  output logic [3:0]       o_Points,
  output logic             o_Valid,
  output logic             o_Zero,
  output logic             o_Active,
  output logic             o_Seeded
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned SPIN_W = 5;
  localparam int unsigned CARD_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_INIT = 16'hACE1;
  localparam logic [SPIN_W-1:0] SPIN_LAST = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_SPIN,
    S_EMIT,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]   seed_val;
  logic [SPIN_W-1:0]   spin_q, spin_d;
  logic                blank_q, blank_d;
  logic [CARD_W-1:0]   card_d, points_d;
  logic                seeded_d;
  logic [CARD_W-1:0]   nib, pick;
  logic                nib_ok;

  // BlackJack value of a rank: Ace counts 11, face cards count 10.
  function automatic logic [CARD_W-1:0] card_points(input logic [CARD_W-1:0] rank);
    logic [CARD_W-1:0] pts;
    if (rank == 4'd1)        pts = 4'd11;
    else if (rank >= 4'd11)  pts = 4'd10;
    else                     pts = rank;
    return pts;
  endfunction

  // Next-state, LFSR and card selection.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    spin_d   = '0;
    blank_d  = 1'b0;
    card_d   = o_Card;
    points_d = o_Points;
    seeded_d = o_Seeded;
    seed_val = LFSR_INIT ^ LFSR_W'(i_Seed);
    nib      = lfsr_q[3:0];
    nib_ok   = (nib >= 4'd1) && (nib <= 4'd13);
    // After 31 rejects the low three bits are mapped onto 1..8 so a draw always terminates.
    pick     = nib_ok ? nib : CARD_W'({1'b0, nib[2:0]} + 4'd1);

    case (state_q)
      S_IDLE: begin
        if (i_Draw) state_d = o_Seeded ? S_SPIN : S_SEED;
      end
      S_SEED: begin
        lfsr_d   = (seed_val == '0) ? LFSR_W'(1) : seed_val;
        seeded_d = 1'b1;
        state_d  = S_SPIN;
      end
      S_SPIN: begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (nib_ok || (spin_q == SPIN_LAST)) begin
          card_d   = pick;
          points_d = card_points(pick);
          state_d  = S_EMIT;
        end else begin
          spin_d = spin_q + SPIN_W'(1);
        end
      end
      S_EMIT: begin
        blank_d = 1'b1;
        state_d = HOLD_EN ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        // First HOLD cycle is blanked while the counter is still clearing.
        if (!blank_q && i_TwoSec) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk_50M) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_INIT;
      spin_q   <= '0;
      blank_q  <= 1'b0;
      o_Card   <= '0;
      o_Points <= '0;
      o_Seeded <= 1'b0;
      o_Ready  <= 1'b1;
      o_Valid  <= 1'b0;
      o_Zero   <= 1'b0;
      o_Active <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      spin_q   <= spin_d;
      blank_q  <= blank_d;
      o_Card   <= card_d;
      o_Points <= points_d;
      o_Seeded <= seeded_d;
      o_Ready  <= (state_d == S_IDLE);
      o_Valid  <= (state_d == S_EMIT);
      o_Zero   <= (state_d == S_EMIT);
      o_Active <= (state_d == S_HOLD);
    end
  end

endmodule
